// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
//   Shared definitions for the iterative multiply/divide unit:
//     - mdu_op_e  : operation encodings carried on the 2-bit op port
//     - mdu_state_e : sequencer states (IDLE -> CALC -> FIX -> IDLE)
//     - mdu_sign_t : sign corrections latched at operation start
//     - helpers classifying an operation as divide and/or signed
// -----------------------------------------------------------------------------
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } mdu_state_e;

  // Corrections applied in FIX. The core loop only ever sees magnitudes.
  //   neg_main : negate the product (multiply) or the quotient (divide)
  //   neg_rem  : negate the remainder (divide only; follows the dividend)
  typedef struct packed {
    logic neg_main;
    logic neg_rem;
  } mdu_sign_t;

  function automatic logic op_is_div(input mdu_op_e o);
    return (o == MDU_DIV) || (o == MDU_DIVU);
  endfunction

  function automatic logic op_is_signed(input mdu_op_e o);
    return (o == MDU_MULT) || (o == MDU_DIV);
  endfunction

endpackage : mdu_pkg

// File: rtl/iter_mult_div.sv
// -----------------------------------------------------------------------------
// iter_mult_div
//   Multi-cycle multiply/divide unit with built-in HI/LO result registers.
//   One result bit is produced per cycle: a request accepted in cycle 0 keeps
//   busy high in cycles 1..XLEN+1 and delivers done plus the new HI/LO in
//   cycle XLEN+2.
//
//   Multiply : shift-add on a 2*XLEN product register; hi/lo = upper/lower half.
//   Divide   : restoring division on a {remainder, quotient} shift register;
//              lo = quotient, hi = remainder. A zero divisor yields lo = all
//              ones, hi = the raw dividend and a div_by_zero pulse with done.
//   Signed ops run on magnitudes; the sign is restored in the FIX cycle.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous, active-high reset
//   start        in   request an operation (honoured only in IDLE)
//   op           in   2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a            in   XLEN  multiplicand / dividend (rs)
//   b            in   XLEN  multiplier / divisor (rt)
//   hi_wen       in   MTHI write enable (honoured only in IDLE)
//   lo_wen       in   MTLO write enable (honoured only in IDLE)
//   wdata        in   XLEN  MTHI/MTLO data
//   busy         out  operation in progress
//   done         out  one-cycle pulse, HI/LO hold the new result
//   div_by_zero  out  pulses with done when a divide had b == 0
//   hi, lo       out  XLEN  HI/LO registers
// -----------------------------------------------------------------------------
module iter_mult_div
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            hi_wen,
  input  logic            lo_wen,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CNT_W = $clog2(XLEN);
  localparam int PW    = 2 * XLEN;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  mdu_state_e      state;
  logic [CNT_W-1:0] cnt;
  mdu_op_e         op_q;
  mdu_sign_t       sign_q;
  logic            dbz_q;
  logic [XLEN-1:0] a_raw;    // unmodified dividend, returned in hi on b == 0
  logic [XLEN-1:0] opnd;     // |a| as multiplicand, or |b| as divisor
  logic [PW-1:0]   acc;      // product, or {remainder, quotient}

  // ---------------------------------------------------------------------------
  // Operand conditioning at acceptance
  // ---------------------------------------------------------------------------
  mdu_op_e         op_in;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  assign op_in = mdu_op_e'(op);
  assign a_neg = op_is_signed(op_in) & a[XLEN-1];
  assign b_neg = op_is_signed(op_in) & b[XLEN-1];
  // The most negative value maps onto itself, which read as unsigned is
  // exactly its magnitude, so no extra bit is needed.
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // ---------------------------------------------------------------------------
  // Multiply step: add the multiplicand into the upper half when the current
  // multiplier bit (acc[0]) is set, then shift the whole register right. The
  // add carries one extra bit that is shifted straight back into range.
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   mul_sum;
  logic [PW-1:0]   mul_next;

  assign mul_sum  = {1'b0, acc[PW-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  // ---------------------------------------------------------------------------
  // Divide step: shift {rem, quot} left by one, try to subtract the divisor
  // from the widened remainder and keep the difference only if it did not
  // borrow. The quotient bit enters at the bottom of the register.
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] div_diff;
  logic            div_fits;
  logic [PW-1:0]   div_next;

  assign rem_sh   = acc[PW-1:XLEN-1];
  assign div_diff = {1'b0, rem_sh} - {2'b00, opnd};
  assign div_fits = ~div_diff[XLEN+1];
  assign div_next = {(div_fits ? div_diff[XLEN-1:0] : rem_sh[XLEN-1:0]),
                     acc[XLEN-2:0], div_fits};

  // ---------------------------------------------------------------------------
  // Final sign correction and divide-by-zero override, consumed in FIX.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] quot;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quot_fixed;
  logic [XLEN-1:0] rem_fixed;
  logic [PW-1:0]   fix_result;

  assign quot       = acc[XLEN-1:0];
  assign rem        = acc[PW-1:XLEN];
  assign quot_fixed = sign_q.neg_main ? -quot : quot;
  assign rem_fixed  = sign_q.neg_rem  ? -rem  : rem;

  // NOTE: every output of a combinational block gets a default assignment
  // first so that no path leaves it unassigned and a latch is inferred.
  always_comb begin
    fix_result = acc;
    if (op_is_div(op_q)) begin
      if (dbz_q) fix_result = {a_raw, {XLEN{1'b1}}};
      else       fix_result = {rem_fixed, quot_fixed};
    end else if (sign_q.neg_main) begin
      fix_result = -acc;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer, datapath registers and HI/LO.
  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the values from before the edge, independent of
  // statement order.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op_q        <= MDU_MULT;
      sign_q      <= '0;
      dbz_q       <= 1'b0;
      a_raw       <= '0;
      opnd        <= '0;
      acc         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;

      unique case (state)
        S_IDLE: begin
          // Register writes land first; a result started in the same cycle
          // overwrites both registers when it completes.
          if (hi_wen) hi <= wdata;
          if (lo_wen) lo <= wdata;

          if (start) begin
            op_q            <= op_in;
            a_raw           <= a;
            dbz_q           <= op_is_div(op_in) && (b == '0);
            sign_q.neg_main <= a_neg ^ b_neg;
            sign_q.neg_rem  <= a_neg;
            cnt             <= CNT_LAST;
            busy            <= 1'b1;
            state           <= S_CALC;
            if (op_is_div(op_in)) begin
              acc  <= {{XLEN{1'b0}}, a_mag};
              opnd <= b_mag;
            end else begin
              acc  <= {{XLEN{1'b0}}, b_mag};
              opnd <= a_mag;
            end
          end
        end

        S_CALC: begin
          acc <= op_is_div(op_q) ? div_next : mul_next;
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - CNT_W'(1);
        end

        S_FIX: begin
          {hi, lo}    <= fix_result;
          done        <= 1'b1;
          div_by_zero <= dbz_q;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule : iter_mult_div

// File: tb/tb_iter_mult_div.sv
// -----------------------------------------------------------------------------
// tb_iter_mult_div
//   Self-checking bench for iter_mult_div (XLEN = 32). Expected results come
//   from plain 64-bit arithmetic on the architectural operands; expected
//   timing comes from the fixed request-to-done latency of XLEN+2 cycles.
//   Inputs change 1 time unit after a rising edge and outputs are sampled
//   there too, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_iter_mult_div;
  import mdu_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            hi_wen;
  logic            lo_wen;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic            div_by_zero;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  int n_asserts = 0;
  int n_fail    = 0;

  iter_mult_div #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .hi_wen      (hi_wen),
    .lo_wen      (lo_wen),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  // Architectural reference: what HI/LO must hold after an operation.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el, output logic ez);
    longint          sx, sy, sp, sq, sr;
    longint unsigned ux, uy, up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    ez = 1'b0;
    eh = '0;
    el = '0;
    case (o)
      2'b00: begin sp = sx * sy; eh = sp[63:32]; el = sp[31:0]; end
      2'b01: begin up = ux * uy; eh = up[63:32]; el = up[31:0]; end
      default: begin
        if (y == 32'd0) begin
          ez = 1'b1; el = 32'hFFFF_FFFF; eh = x;
        end else if (o == 2'b10) begin
          sq = sx / sy; sr = sx % sy;          // truncating division
          el = sq[31:0]; eh = sr[31:0];
        end else begin
          up = ux / uy; el = up[31:0];
          up = ux % uy; eh = up[31:0];
        end
      end
    endcase
  endfunction

  // Issue one operation and follow it cycle by cycle to one cycle past done.
  //   inject : raise start and hi_wen mid-operation (both must be ignored)
  //   mt_now : raise hi_wen together with start (write applies, later lost)
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit inject, input bit mt_now);
    logic [31:0] eh, el;
    logic        ez;
    model(o, x, y, eh, el, ez);

    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    if (mt_now) begin hi_wen = 1'b1; wdata = 32'h0000_ABCD; end

    for (int c = 1; c <= XLEN + 3; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        // Operands wander after acceptance; the result must not care.
        start = 1'b0; hi_wen = 1'b0;
        op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
        if (mt_now) check({tag, "_mthi_with_start"}, hi, 32'h0000_ABCD);
      end
      if (inject && c == 5) begin start = 1'b1; hi_wen = 1'b1; wdata = 32'h0000_1234; end
      if (inject && c == 6) begin start = 1'b0; hi_wen = 1'b0; end

      if (c <= XLEN + 2) begin
        check($sformatf("%s_busy_c%0d", tag, c), busy, (c <= XLEN + 1));
        check($sformatf("%s_done_c%0d", tag, c), done, (c == XLEN + 2));
      end
      if (c == XLEN + 2) begin
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
        check({tag, "_dbz"}, div_by_zero, ez);
      end
      if (c == XLEN + 3) begin
        check({tag, "_done_once"}, done, 1'b0);
        check({tag, "_dbz_once"}, div_by_zero, 1'b0);
        check({tag, "_hi_hold"}, hi, eh);
        check({tag, "_lo_hold"}, lo, el);
      end
    end
  endtask

  initial begin
    bit          saw_done;
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;

    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_wen = 1'b0; lo_wen = 1'b0; wdata = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dbz", div_by_zero, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    rst = 1'b0;

    // Directed cases from the plan.
    run_op("mult_neg3x7",  MDU_MULT,  32'hFFFF_FFFD, 32'd7,        1'b0, 1'b0);
    run_op("multu_max",    MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("div_neg7_2",   MDU_DIV,   32'hFFFF_FFF9, 32'd2,        1'b0, 1'b0);
    run_op("divu_7_2",     MDU_DIVU,  32'd7,         32'd2,        1'b0, 1'b0);
    run_op("div_ovf",      MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("divu_by0",     MDU_DIVU,  32'd5,         32'd0,        1'b0, 1'b0);
    run_op("div_by0_neg",  MDU_DIV,   32'hFFFF_FF00, 32'd0,        1'b0, 1'b0);
    run_op("mult_inject",  MDU_MULT,  32'h1234_5678, 32'hFEDC_BA98, 1'b1, 1'b0);
    run_op("divu_mt_now",  MDU_DIVU,  32'hDEAD_BEEF, 32'd13,       1'b0, 1'b1);

    // Reset in cycle 10 of an operation: partial result discarded, no done.
    @(posedge clk); #1;
    start = 1'b1; op = MDU_MULTU; a = 32'h0001_0001; b = 32'h0000_0003;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < XLEN + 8; c++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("midrst_no_done", saw_done, 1'b0);
    check("midrst_idle", busy, 1'b0);

    // MTLO then MTHI in IDLE.
    lo_wen = 1'b1; wdata = 32'h0000_CAFE;
    @(posedge clk); #1;
    lo_wen = 1'b0;
    check("mtlo_lo", lo, 32'h0000_CAFE);
    check("mtlo_hi_untouched", hi, 32'h0);
    hi_wen = 1'b1; wdata = 32'h8765_4321;
    @(posedge clk); #1;
    hi_wen = 1'b0;
    check("mthi_hi", hi, 32'h8765_4321);
    check("mthi_lo_untouched", lo, 32'h0000_CAFE);

    // Randomised operations, biased toward the interesting divisors.
    for (int i = 0; i < 24; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       r_b = 32'd0;
        1:       r_b = 32'($urandom_range(1, 15));
        2:       r_b = 32'hFFFF_FFFF;
        default: r_b = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), r_op, r_a, r_b, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule : tb_iter_mult_div

// File: doc/iter_mult_div.md
Name: iter_mult_div

Overview:
- Parametrised, multi-cycle multiply/divide unit with integrated HI/LO result registers.
- Successor to the combinational MultDiv plus LoHiRegister pair; intended for the pipelined core.
- Computes one result bit per cycle; handshake is start/busy/done, so the pipeline stalls on HI/LO reads while busy.
- Supports MULT, MULTU, DIV, DIVU, and the MTHI/MTLO register writes.

Parameters:
- XLEN, 32, operand/register width; must be >= 2.
- CNT_W, $clog2(XLEN), iteration counter width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request an operation; accepted only in IDLE.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  XLEN  rs operand (multiplicand / dividend).
- b  input  XLEN  rt operand (multiplier / divisor).
- hi_wen  input  1  MTHI write enable.
- lo_wen  input  1  MTLO write enable.
- wdata  input  XLEN  MTHI/MTLO data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; HI/LO hold the new result.
- div_by_zero  output  1  pulses with done when a divide had b==0.
- hi  output  XLEN  HI register.
- lo  output  XLEN  LO register.

Behaviour:
- Reset (synchronous, rst high at a rising edge): state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0. Reset overrides everything, including an operation in flight; that partial result is discarded.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - start=1 latches op, magnitude operands |a| and |b| (sign applied for signed ops), and the result sign flags; counter=XLEN-1; next state CALC.
  - start=0 stays in IDLE.
- CALC, multiply:
  - Shift-add on a 2*XLEN product register.
  - Decrements counter each cycle; at counter==0 the next state is FIX.
  - Duration is exactly XLEN cycles.
- CALC, divide:
  - Restoring divide on the remainder/quotient shift register.
  - Same counter rule and same XLEN-cycle duration as multiply.
- FIX (1 cycle):
  - Negate the product if signs differ (MULT).
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a) (DIV).
  - Write {hi,lo} at the end of this cycle; register done=1; next state IDLE.
- Latency:
  - start high in cycle 0.
  - busy=1 in cycles 1..XLEN+1.
  - done=1 and new hi/lo visible in cycle XLEN+2, with busy=0 in that same cycle.
  - done is high for exactly one cycle.
- Results:
  - Multiply: hi=upper XLEN bits, lo=lower XLEN bits of the 2*XLEN product.
  - Divide: lo=quotient, hi=remainder.
- Divide by zero:
  - Same latency as a normal divide.
  - lo=all ones, hi=a (the raw latched operand), div_by_zero=1 together with done.
- Signed overflow (a=MIN, b=-1): lo=MIN, hi=0. This is natural two's-complement wrap; no flag.
- start while busy: ignored; no queueing.
- hi_wen/lo_wen:
  - In IDLE, wdata is written at the edge.
  - While busy, the write is ignored.
  - Simultaneous start with hi_wen/lo_wen in IDLE: the write is applied, the operation starts, and the result later overwrites both registers.
- Operand changes on a/b/op after acceptance have no effect.
- hi and lo hold their value between writes.

Decomposition:
- mdu_pkg holds:
  - op encodings MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU;
  - state encodings S_IDLE, S_CALC, S_FIX.
- Single module; no sub-module required. Magnitude and negate are inline expressions.

Test Plan:
- MULT, a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done exactly in cycle 34 after the start cycle; busy high in cycles 1..33.
- MULTU, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV, a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU, a=7, b=2 -> lo=3, hi=1.
- DIV, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- DIVU, a=5, b=0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1 with done in cycle 34.
- Sequencing:
  - Raise start and hi_wen (wdata=0x1234) mid-operation -> both ignored; the original result is delivered.
  - Raise rst in cycle 10 of an operation -> in the following cycle busy=0, hi=lo=0, and done never pulses.
  - MTLO in IDLE with 0xCAFE -> lo=0x0000CAFE in the next cycle.
